// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/execute sequencer for the 4-bit ALU, owning the A/B registers,
// the carry/zero flags and a backpressured output port.
module alu_sequencer #(
   parameter int DATA_WIDTH = 4,
   parameter int OPERATION_CODE_WIDTH = 3
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            instr_valid_i,
   output logic                            instr_ready_o,
   input  logic [DATA_WIDTH+3:0]           instr_i,
   output logic [DATA_WIDTH-1:0]           alu_a_o,
   output logic [DATA_WIDTH-1:0]           alu_b_o,
   output logic [OPERATION_CODE_WIDTH-1:0] alu_oc_o,
   input  logic [DATA_WIDTH-1:0]           alu_result_i,
   input  logic                            alu_carry_i,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic [DATA_WIDTH-1:0]           out_data_o,
   output logic                            carry_o,
   output logic                            zero_o,
   output logic                            halted_o
);
   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_OUT, S_HALT} state_t;
   state_t state;
   logic [DATA_WIDTH+3:0] ir;
   logic [3:0] op;
   logic [DATA_WIDTH-1:0] imm, a, b;
   assign op = ir[DATA_WIDTH+3:DATA_WIDTH];
   assign imm = ir[DATA_WIDTH-1:0];
   assign alu_a_o = a;
   assign alu_b_o = b;
   // the ALU sees a live opcode only while an ALU instruction is executing
   assign alu_oc_o = (state == S_EXEC && op[3]) ? op[OPERATION_CODE_WIDTH-1:0] : '0;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_FETCH;
         ir <= '0;
         a <= '0;
         b <= '0;
         carry_o <= 1'b0;
         zero_o <= 1'b1;
         out_data_o <= '0;
         out_valid_o <= 1'b0;
         halted_o <= 1'b0;
         instr_ready_o <= 1'b1;
      end else begin
         case (state)
            S_FETCH: if (instr_valid_i) begin
               ir <= instr_i;
               state <= S_EXEC;
               instr_ready_o <= 1'b0;
            end
            S_EXEC: begin
               state <= op == 4'h5 ? S_OUT : op == 4'h7 ? S_HALT : S_FETCH;
               instr_ready_o <= op != 4'h5 && op != 4'h7;
               out_valid_o <= op == 4'h5;
               halted_o <= op == 4'h7;
               if (op[3]) begin
                  a <= alu_result_i;
                  zero_o <= alu_result_i == '0;
                  if (op[2]) carry_o <= alu_carry_i;
               end else if (op == 4'h1) begin
                  a <= imm;
                  zero_o <= imm == '0;
               end else if (op == 4'h2) begin
                  b <= imm;
               end else if (op == 4'h3) begin
                  a <= b;
                  b <= a;
                  zero_o <= b == '0;
               end else if (op == 4'h5) begin
                  out_data_o <= a;
               end
            end
            S_OUT: if (out_ready_i) begin
               state <= S_FETCH;
               out_valid_o <= 1'b0;
               instr_ready_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed instruction streams scored against an
// architectural model of the A/B/flag state and the OUT stream.
module tb_alu_sequencer;
   logic clk = 0, rst = 1;
   logic instr_valid, instr_ready, out_valid, out_ready, carry, zero, halted, alu_c;
   logic [7:0] instr;
   logic [3:0] alu_a, alu_b, alu_r, out_data;
   logic [2:0] alu_oc;
   logic [4:0] s;
   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
      .instr_i(instr), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_oc_o(alu_oc),
      .alu_result_i(alu_r), .alu_carry_i(alu_c), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_data_o(out_data), .carry_o(carry), .zero_o(zero),
      .halted_o(halted)
   );

   // stand-in for the 4-bit ALU downstream
   always_comb begin
      s = {1'b0, alu_a} + {1'b0, alu_b};
      {alu_c, alu_r} = 5'd0;
      case (alu_oc)
         3'd1: alu_r = alu_a ^ alu_b;
         3'd2: alu_r = alu_a & alu_b;
         3'd3: alu_r = alu_a | alu_b;
         3'd4, 3'd5: {alu_c, alu_r} = s;
         3'd6, 3'd7: begin alu_r = alu_a - alu_b; alu_c = alu_a >= alu_b; end
         default: ;
      endcase
   end

   typedef struct {int a; int b; int c; int z; int rdy;} exp_t;
   exp_t rq[$];
   int oq[$];
   exp_t e;
   int vectors = 0, miscompares = 0;
   int ma, mb, mc, mz, cd = 0;
   logic [3:0] cop;
   logic rr = 0;

   task automatic chk(input string n, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask

   task automatic mreset();
      ma = 0; mb = 0; mc = 0; mz = 1;
   endtask

   task automatic model(input int op, input int imm);
      int t;
      if (op == 1) ma = imm;
      else if (op == 2) mb = imm;
      else if (op == 3) begin t = ma; ma = mb; mb = t; end
      else if (op == 5) oq.push_back(ma);
      else if (op == 8) ma = 0;
      else if (op == 9) ma = ma ^ mb;
      else if (op == 10) ma = ma & mb;
      else if (op == 11) ma = ma | mb;
      else if (op == 12 || op == 13) begin mc = (ma + mb) / 16; ma = (ma + mb) % 16; end
      else if (op >= 14) begin mc = ma >= mb; ma = (ma - mb + 16) % 16; end
      if (op == 1 || op == 3 || op >= 8) mz = ma == 0;
      rq.push_back('{ma, mb, mc, mz, (op != 5 && op != 7) ? 1 : 0});
   endtask

   task automatic issue(input int op, input int imm);
      int t = 0;
      instr_valid = 1;
      instr = {op[3:0], imm[3:0]};
      @(negedge clk);
      while (!instr_ready && t < 200) begin @(negedge clk); t++; end
      if (!instr_ready) begin
         chk("issue_timeout", 0, 1);
         instr_valid = 0;
         return;
      end
      model(op, imm);
      @(posedge clk); #1;
      instr_valid = 0;
      instr = 8'($urandom);
   endtask

   task automatic reset_checks();
      chk("rst_a", alu_a, 0); chk("rst_b", alu_b, 0); chk("rst_carry", carry, 0);
      chk("rst_zero", zero, 1); chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0); chk("rst_halted", halted, 0);
      chk("rst_ready", instr_ready, 1);
   endtask

   always @(posedge clk) if (rr) #1 out_ready = 1'($urandom_range(0, 1));

   // monitor: register state is scored the cycle after EXEC, OUT data while valid
   always @(negedge clk) begin
      if (rst) begin
         cd = 0; rq.delete(); oq.delete();
      end else begin
         chk("alu_oc", alu_oc, (cd == 2 && cop[3]) ? cop[2:0] : 0);
         if (cd == 2) chk("exec_ready", instr_ready, 0);
         if (cd == 1) begin
            if (rq.size() == 0) chk("rq_empty", 1, 0);
            else begin
               e = rq.pop_front();
               chk("a", alu_a, e.a); chk("b", alu_b, e.b); chk("carry", carry, e.c);
               chk("zero", zero, e.z); chk("ready_after", instr_ready, e.rdy);
            end
         end
         if (cd > 0) cd--;
         if (instr_valid && instr_ready) begin cd = 2; cop = instr[7:4]; end
         if (out_valid) begin
            if (oq.size() == 0) chk("oq_empty", 1, 0);
            else begin
               chk("out_data", out_data, oq[0]);
               if (out_ready) void'(oq.pop_front());
            end
         end
      end
   end

   initial begin
      instr_valid = 0; instr = 0; out_ready = 1;
      mreset();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk) reset_checks();
      @(posedge clk); #1;
      issue(1, 5); issue(2, 3); issue(12, 0);
      issue(1, 5); issue(2, 3); issue(14, 0);
      issue(1, 3); issue(2, 5); issue(14, 0);
      issue(1, 15); issue(2, 1); issue(12, 0); issue(11, 0);
      out_ready = 0;
      issue(1, 10); issue(5, 0);
      fork
         begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk("stall_valid", out_valid, 1); chk("stall_ready", instr_ready, 0);
            end
            @(posedge clk); #1 out_ready = 1;
            @(negedge clk); chk("hs_valid", out_valid, 1);
            @(negedge clk); chk("post_hs_valid", out_valid, 0); chk("post_hs_ready", instr_ready, 1);
         end
         issue(2, 9);
      join
      issue(1, 12); issue(2, 6); issue(3, 0); issue(9, 0); issue(10, 0); issue(8, 0);
      rr = 1;
      for (int i = 0; i < 300; i++) begin
         int op;
         op = $urandom_range(0, 15);
         if (op == 7) op = 0;
         issue(op, $urandom_range(0, 15));
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      rr = 0;
      @(posedge clk); #1 out_ready = 1;
      repeat (4) @(posedge clk);
      #1 issue(7, 0);
      instr_valid = 1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("halted", halted, 1); chk("halt_ready", instr_ready, 0);
      end
      @(posedge clk); #1 rst = 1; instr_valid = 0; mreset();
      @(posedge clk); #1 rst = 0;
      @(negedge clk) reset_checks();
      @(posedge clk); #1;
      issue(1, 7);
      rst = 1; mreset();
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("abort_a", alu_a, 0); chk("abort_zero", zero, 1); chk("abort_ready", instr_ready, 1);
      @(posedge clk); #1;
      issue(1, 7);
      repeat (2) @(negedge clk);
      chk("final_a", alu_a, 7);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
